// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LDSTALL,
    FLUSH
  } state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [1:0] J_NONE = 2'b00;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle between the ID/EX/MEM/WB stages and the
// hazard controller.
interface hazard_ctrl_unit_if #(
  parameter int RAW = 3
);

  logic [RAW-1:0] r1_id;
  logic [RAW-1:0] r2_id;
  logic [RAW-1:0] r1_ex;
  logic [RAW-1:0] r2_ex;
  logic [RAW-1:0] rd_ex;
  logic           mem_read_ex;
  logic [RAW-1:0] rd_mem;
  logic           reg_write_mem;
  logic [RAW-1:0] rd_wb;
  logic           reg_write_wb;
  logic [1:0]     j_type;

  logic           stall_pc;
  logic           stall_id;
  logic           bubble_ex;
  logic           flush;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;

  modport master (
    output r1_id, r2_id, r1_ex, r2_ex,
    output rd_ex, mem_read_ex,
    output rd_mem, reg_write_mem,
    output rd_wb, reg_write_wb,
    output j_type,
    input  stall_pc, stall_id, bubble_ex,
    input  flush, fwd_a, fwd_b
  );

  modport slave (
    input  r1_id, r2_id, r1_ex, r2_ex,
    input  rd_ex, mem_read_ex,
    input  rd_mem, reg_write_mem,
    input  rd_wb, reg_write_wb,
    input  j_type,
    output stall_pc, stall_id, bubble_ex,
    output flush, fwd_a, fwd_b
  );

endinterface

// File: rtl/fwd_sel.sv
// EX operand bypass select; MEM result wins over WB result.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int RAW         = 3,
  parameter int ZERO_REG_HW = 0
) (
  input  logic [RAW-1:0] src,
  input  logic [RAW-1:0] rd_mem,
  input  logic           reg_write_mem,
  input  logic [RAW-1:0] rd_wb,
  input  logic           reg_write_wb,
  output logic [1:0]     sel
);

  logic zeroMem;
  logic zeroWb;
  logic hitMem;
  logic hitWb;

  assign zeroMem = (ZERO_REG_HW != 0) && (rd_mem == '0);
  assign zeroWb  = (ZERO_REG_HW != 0) && (rd_wb == '0);

  assign hitMem = reg_write_mem && (src == rd_mem) && !zeroMem;
  assign hitWb  = reg_write_wb && (src == rd_wb) && !zeroWb;

  always_comb begin
    sel = FWD_NONE;
    priority case (1'b1)
      hitMem:  sel = FWD_MEM;
      hitWb:   sel = FWD_WB;
      default: sel = FWD_NONE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall, jump flush and forwarding control for the 5-stage
// core, plus a saturating stall/flush cycle counter.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int RAW          = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_STAGES = 1,
  parameter int ZERO_REG_HW  = 0,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_ctrl_unit_if.slave hz,
  input  logic              perf_clr,
  output logic              busy,
  output logic [PERF_W-1:0] perf_cnt
);

  function automatic logic regMatch(
    input logic [RAW-1:0] a,
    input logic [RAW-1:0] b
  );
    return (a == b) && !((ZERO_REG_HW != 0) && (b == '0));
  endfunction

  state_t     state;
  state_t     nState;
  logic [2:0] cnt;
  logic [2:0] nCnt;
  logic       stall;
  logic       flushC;
  logic       loadUse;
  logic       jump;
  logic [1:0] selA;
  logic [1:0] selB;

  assign loadUse = hz.mem_read_ex &&
                   (regMatch(hz.r1_id, hz.rd_ex) ||
                    regMatch(hz.r2_id, hz.rd_ex));
  assign jump    = (hz.j_type != J_NONE);

  fwd_sel #(
    .RAW         (RAW),
    .ZERO_REG_HW (ZERO_REG_HW)
  ) uFwdA (
    .src           (hz.r1_ex),
    .rd_mem        (hz.rd_mem),
    .reg_write_mem (hz.reg_write_mem),
    .rd_wb         (hz.rd_wb),
    .reg_write_wb  (hz.reg_write_wb),
    .sel           (selA)
  );

  fwd_sel #(
    .RAW         (RAW),
    .ZERO_REG_HW (ZERO_REG_HW)
  ) uFwdB (
    .src           (hz.r2_ex),
    .rd_mem        (hz.rd_mem),
    .reg_write_mem (hz.reg_write_mem),
    .rd_wb         (hz.rd_wb),
    .reg_write_wb  (hz.reg_write_wb),
    .sel           (selB)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nState;
      cnt   <= nCnt;
    end
  end

  // The first stall/flush cycle is issued from IDLE, so the extra
  // states only cover the remaining LAT-1 / STAGES-1 cycles.
  always_comb begin
    nState = state;
    nCnt   = cnt;
    stall  = 1'b0;
    flushC = 1'b0;
    unique case (state)
      IDLE: begin
        if (loadUse) begin
          stall = 1'b1;
          if (LOAD_LAT > 1) begin
            nState = LDSTALL;
            nCnt   = 3'(LOAD_LAT - 1);
          end
        end else if (jump) begin
          flushC = 1'b1;
          if (FLUSH_STAGES > 1) begin
            nState = FLUSH;
            nCnt   = 3'(FLUSH_STAGES - 1);
          end
        end
      end
      LDSTALL: begin
        stall = 1'b1;
        nCnt  = cnt - 3'd1;
        if (cnt == 3'd1) nState = IDLE;
      end
      FLUSH: begin
        flushC = 1'b1;
        nCnt   = cnt - 3'd1;
        if (cnt == 3'd1) nState = IDLE;
      end
      default: begin
        nState = IDLE;
        nCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (perf_clr) begin
      perf_cnt <= '0;
    end else if ((stall || flushC) && !(&perf_cnt)) begin
      perf_cnt <= perf_cnt + 1'b1;
    end
  end

  assign hz.stall_pc  = rst_n && stall;
  assign hz.stall_id  = rst_n && stall;
  assign hz.bubble_ex = rst_n && stall;
  assign hz.flush     = rst_n && flushC;
  assign hz.fwd_a     = rst_n ? selA : FWD_NONE;
  assign hz.fwd_b     = rst_n ? selB : FWD_NONE;
  assign busy         = rst_n && (state != IDLE);

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the 5-stage core: load-use stall detection, multi-cycle stalls for slow memory reads, multi-stage flush on jumps, and EX-stage operand forwarding selects.
- Adds a saturating stall/flush performance counter.
- Sits beside the ID/EX pipeline registers and drives PC enable, IF/ID enable, ID/EX bubble, flush and forwarding muxes.

Parameters:
- RAW, 3, register address width.
- LOAD_LAT, 1, memory read latency in stall cycles per load-use hazard (legal 1..7).
- FLUSH_STAGES, 1, consecutive cycles `flush` stays high after a taken jump (legal 1..3).
- ZERO_REG_HW, 0, when 1, register 0 never causes a hazard or forward.
- PERF_W, 16, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- r1_id  in  RAW  source 1 of instruction in ID.
- r2_id  in  RAW  source 2 of instruction in ID.
- r1_ex  in  RAW  source 1 of instruction in EX.
- r2_ex  in  RAW  source 2 of instruction in EX.
- rd_ex  in  RAW  destination in EX.
- mem_read_ex  in  1  EX instruction is a load.
- rd_mem  in  RAW  destination in MEM.
- reg_write_mem  in  1  MEM instruction writes rd_mem.
- rd_wb  in  RAW  destination in WB.
- reg_write_wb  in  1  WB instruction writes rd_wb.
- j_type  in  2  jump type in ID; 00 = none.
- perf_clr  in  1  synchronous clear of perf_cnt.
- stall_pc  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- bubble_ex  out  1  load NOP into ID/EX.
- flush  out  1  squash IF/ID contents.
- fwd_a  out  2  EX operand A select.
- fwd_b  out  2  EX operand B select.
- busy  out  1  FSM not in IDLE.
- perf_cnt  out  PERF_W  stall+flush cycle count.

Behaviour:

Reset:
- While rst_n is low: FSM = IDLE, counters = 0, and every output is 0, including the combinational ones, which are gated by rst_n.

Hazard and forwarding terms:
- `match(a,b)` is `a==b && !(ZERO_REG_HW && b==0)`.
- `lu` (load-use hazard) is `mem_read_ex && (match(r1_id,rd_ex) || match(r2_id,rd_ex))`.
- fwd_a: 10 when `reg_write_mem && match(r1_ex,rd_mem)`; else 01 when `reg_write_wb && match(r1_ex,rd_wb)`; else 00. MEM has priority over WB. fwd_b is the same using r2_ex. Both are purely combinational, independent of FSM state.

FSM states: IDLE, LDSTALL, FLUSH. One 3-bit down-counter `cnt`.

IDLE:
- If `lu`: stall_pc = stall_id = bubble_ex = 1 this cycle (combinational). If LOAD_LAT>1, go to LDSTALL with cnt = LOAD_LAT-1.
- Else if `j_type!=00`: flush = 1 this cycle. If FLUSH_STAGES>1, go to FLUSH with cnt = FLUSH_STAGES-1.
- A load-use hazard has priority over a jump in the same cycle; the jump is taken after the stall, when it re-presents.

LDSTALL:
- stall_pc = stall_id = bubble_ex = 1, flush = 0; cnt decrements each cycle.
- When cnt==1, the next state is IDLE.
- j_type and `lu` are ignored here.

FLUSH:
- flush = 1, no stalls; cnt decrements; when cnt==1, the next state is IDLE.
- j_type and `lu` are ignored here because ID holds a wrong-path instruction.

Other rules:
- busy = (state != IDLE).
- Total stall length per load-use hazard is exactly LOAD_LAT cycles; total flush length per jump is exactly FLUSH_STAGES cycles.
- perf_cnt increments by 1 in each cycle where stall_pc or flush is 1. It saturates at all-ones and does not wrap. perf_clr has priority over increment (result 0).
- Asserting rst_n low mid-stall or mid-flush returns to IDLE immediately and drops all outputs the same instant; there is no resumption after release.
- LOAD_LAT=1 or FLUSH_STAGES=1 means the FSM never leaves IDLE for that event.

Decomposition:
- Shared package `hazard_pkg`:
  - state enum {IDLE, LDSTALL, FLUSH};
  - forwarding constants FWD_NONE=00, FWD_WB=01, FWD_MEM=10;
  - jump type constant J_NONE=00.
- One sub-module, `fwd_sel`, instantiated twice (operands A and B). Inputs: src, rd_mem, reg_write_mem, rd_wb, reg_write_wb. Output: the 2-bit select.

Test Plan:
1. Reset: rst_n=0 with mem_read_ex=1, rd_ex=r1_id=3 -> all outputs 0. Release -> stall_pc=stall_id=bubble_ex=1 same cycle.
2. LOAD_LAT=3: load-use on r2_id=5 -> stall_pc high for exactly 3 cycles; busy high for cycles 1-2 after the hazard cycle; then IDLE, perf_cnt=3.
3. Same cycle: load-use hazard plus j_type=01 -> flush=0 during the stall. Jump re-presented after the stall -> flush=1; with FLUSH_STAGES=2, flush is held 2 cycles and a j_type=10 arriving during FLUSH is ignored.
4. Forwarding: r1_ex=r2_ex=4, rd_mem=rd_wb=4, both writes=1 -> fwd_a=fwd_b=10. Drop reg_write_mem -> 01. With ZERO_REG_HW=1 and all regs 0 -> 00, and no stall with mem_read_ex=1.
5. rst_n pulsed low in the 2nd LDSTALL cycle (LOAD_LAT=4) -> outputs 0 immediately, perf_cnt=0. After release no stall unless the hazard is still present.
6. PERF_W=4: 20 stall cycles -> perf_cnt saturates at 15. perf_clr coinciding with a stall cycle -> 0.
